// File: rtl/fdiv_sqrt_issue_arbiter.sv
// Round-robin issue arbiter that shares one iterative FP divide/sqrt unit between SMT threads.
// Latches the winner's operands, sequences start/kill/done and routes the result to its owner.
module fdiv_sqrt_issue_arbiter #(
    parameter int NUM_THREADS = 2,
    parameter int TID_W       = 1,
    parameter int TIMEOUT     = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_THREADS-1:0]      i_req,
    input  logic [NUM_THREADS-1:0]      i_req_is_sqrt,
    input  logic [NUM_THREADS*32-1:0]   i_req_lhs,
    input  logic [NUM_THREADS*32-1:0]   i_req_rhs,
    input  logic [NUM_THREADS*3-1:0]    i_req_rm,
    input  logic [NUM_THREADS-1:0]      i_flush,
    output logic [NUM_THREADS-1:0]      o_grant,
    output logic [NUM_THREADS-1:0]      o_resp_valid,
    output logic [31:0]                 o_resp_data,
    output logic [4:0]                  o_resp_fflags,
    output logic                        o_busy,
    output logic                        o_err_timeout,
    output logic                        o_unit_start,
    output logic                        o_unit_is_sqrt,
    output logic [31:0]                 o_unit_lhs,
    output logic [31:0]                 o_unit_rhs,
    output logic [2:0]                  o_unit_rm,
    output logic                        o_unit_kill,
    input  logic                        i_unit_done,
    input  logic [31:0]                 i_unit_result,
    input  logic [4:0]                  i_unit_fflags
);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [TID_W-1:0]       r_rr_ptr;
    logic [TID_W-1:0]       r_owner;
    logic [TID_W-1:0]       w_pick;
    logic                   w_pick_vld;
    logic                   w_owner_flush;
    logic                   w_launch;
    logic                   w_accept;
    logic                   w_kill_nxt;
    logic                   w_timeout_hit;
    logic [NUM_THREADS-1:0] w_elig;
    logic [NUM_THREADS-1:0] w_grant_nxt;
    logic [NUM_THREADS-1:0] w_resp_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [NUM_THREADS-1:0] r_grant;
    logic [NUM_THREADS-1:0] r_resp_oh;
    logic [31:0]            r_resp_data;
    logic [4:0]             r_resp_fflags;
    logic                   r_err_timeout;
    logic                   r_unit_start;
    logic                   r_unit_kill;
    logic                   r_unit_is_sqrt;
    logic [31:0]            r_unit_lhs;
    logic [31:0]            r_unit_rhs;
    logic [2:0]             r_unit_rm;

    assign w_elig        = i_req & ~i_flush;
    assign w_owner_flush = i_flush[r_owner];

    // Round-robin search for the first eligible thread at or after r_rr_ptr
    always_comb begin
        int               v_idx;
        logic [TID_W-1:0] v_sel;
        w_pick     = '0;
        w_pick_vld = 1'b0;
        v_idx      = 0;
        v_sel      = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            v_idx = (int'(r_rr_ptr) + i) % NUM_THREADS;
            v_sel = TID_W'(v_idx);
            if (!w_pick_vld && w_elig[v_sel]) begin
                w_pick_vld = 1'b1;
                w_pick     = v_sel;
            end else begin
                w_pick_vld = w_pick_vld;
            end
        end
    end

    // Next-state logic and next values of the pulsed outputs
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = '0;
        w_resp_nxt    = '0;
        w_kill_nxt    = 1'b0;
        w_timeout_hit = 1'b0;
        w_launch      = 1'b0;
        w_accept      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt         = ST_BUSY;
                    w_launch            = 1'b1;
                    w_grant_nxt[w_pick] = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (i_unit_done && !w_owner_flush) begin
                    w_state_nxt         = ST_RESP;
                    w_accept            = 1'b1;
                    w_resp_nxt[r_owner] = 1'b1;
                end else if (w_owner_flush) begin
                    // A flush racing the done pulse needs no kill: the unit is already idle
                    w_state_nxt = ST_IDLE;
                    w_kill_nxt  = !i_unit_done;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_state_nxt   = ST_IDLE;
                    w_kill_nxt    = 1'b1;
                    w_timeout_hit = 1'b1;
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand latch, owner/pointer bookkeeping, BUSY counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr       <= '0;
            r_owner        <= '0;
            r_cnt          <= '0;
            r_grant        <= '0;
            r_resp_oh      <= '0;
            r_resp_data    <= 32'd0;
            r_resp_fflags  <= 5'd0;
            r_err_timeout  <= 1'b0;
            r_unit_start   <= 1'b0;
            r_unit_kill    <= 1'b0;
            r_unit_is_sqrt <= 1'b0;
            r_unit_lhs     <= 32'd0;
            r_unit_rhs     <= 32'd0;
            r_unit_rm      <= 3'd0;
        end else begin
            r_grant      <= w_grant_nxt;
            r_unit_start <= w_launch;
            r_unit_kill  <= w_kill_nxt;
            r_resp_oh    <= w_resp_nxt;
            if (w_timeout_hit) begin
                r_err_timeout <= 1'b1;
            end else begin
                r_err_timeout <= r_err_timeout;
            end
            if (w_launch) begin
                r_owner        <= w_pick;
                r_rr_ptr       <= TID_W'((int'(w_pick) + 1) % NUM_THREADS);
                r_cnt          <= '0;
                r_unit_is_sqrt <= i_req_is_sqrt[w_pick];
                r_unit_lhs     <= i_req_lhs[32*w_pick +: 32];
                r_unit_rhs     <= i_req_is_sqrt[w_pick] ? 32'd0 : i_req_rhs[32*w_pick +: 32];
                r_unit_rm      <= i_req_rm[3*w_pick +: 3];
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_cnt <= r_cnt;
            end
            if (w_accept) begin
                r_resp_data   <= i_unit_result;
                r_resp_fflags <= i_unit_fflags;
            end else begin
                r_resp_data   <= r_resp_data;
                r_resp_fflags <= r_resp_fflags;
            end
        end
    end

    // A flush of the owner in its response cycle must still cancel the response
    assign o_resp_valid   = r_resp_oh & ~i_flush;
    assign o_grant        = r_grant;
    assign o_resp_data    = r_resp_data;
    assign o_resp_fflags  = r_resp_fflags;
    assign o_busy         = (r_state != ST_IDLE);
    assign o_err_timeout  = r_err_timeout;
    assign o_unit_start   = r_unit_start;
    assign o_unit_kill    = r_unit_kill;
    assign o_unit_is_sqrt = r_unit_is_sqrt;
    assign o_unit_lhs     = r_unit_lhs;
    assign o_unit_rhs     = r_unit_rhs;
    assign o_unit_rm      = r_unit_rm;

endmodule

// File: tb/tb_fdiv_sqrt_issue_arbiter.sv
// Randomized bench for fdiv_sqrt_issue_arbiter; a transaction-level model schedules the
// expected grant/response/kill events into per-cycle slots and every cycle is compared.
module tb_fdiv_sqrt_issue_arbiter;
    localparam int NT   = 2;
    localparam int TO   = 64;
    localparam int MAXC = 8192;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [NT-1:0]    req, req_is_sqrt, flush, grant, resp_valid;
    logic [NT*32-1:0] req_lhs, req_rhs;
    logic [NT*3-1:0]  req_rm;
    logic [31:0]      resp_data, unit_lhs, unit_rhs, unit_result;
    logic [4:0]       resp_fflags, unit_fflags;
    logic [2:0]       unit_rm;
    logic             busy, err_timeout, unit_start, unit_is_sqrt, unit_kill, unit_done;

    fdiv_sqrt_issue_arbiter #(.NUM_THREADS(NT), .TID_W(1), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(req), .i_req_is_sqrt(req_is_sqrt), .i_req_lhs(req_lhs), .i_req_rhs(req_rhs),
        .i_req_rm(req_rm), .i_flush(flush),
        .o_grant(grant), .o_resp_valid(resp_valid), .o_resp_data(resp_data),
        .o_resp_fflags(resp_fflags), .o_busy(busy), .o_err_timeout(err_timeout),
        .o_unit_start(unit_start), .o_unit_is_sqrt(unit_is_sqrt), .o_unit_lhs(unit_lhs),
        .o_unit_rhs(unit_rhs), .o_unit_rm(unit_rm), .o_unit_kill(unit_kill),
        .i_unit_done(unit_done), .i_unit_result(unit_result), .i_unit_fflags(unit_fflags)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = -1;

    // expected events per cycle
    int         e_grant [MAXC];
    int         e_resp  [MAXC];
    bit         e_kill  [MAXC];
    bit         e_busy  [MAXC];
    logic [31:0] e_data [MAXC];
    logic [4:0]  e_flags[MAXC];

    // threads
    bit          pend  [NT];
    logic [31:0] t_lhs [NT];
    logic [31:0] t_rhs [NT];
    logic [2:0]  t_rm  [NT];
    bit          t_sqrt[NT];

    // model of the in-flight transaction
    bit          m_active;
    int          m_own, m_g, m_rr, m_free, err_from;
    logic [31:0] m_lhs, m_rhs;
    logic [2:0]  m_rm;
    bit          m_sqrt;

    // unit behaviour
    int          done_cyc;
    logic [31:0] u_res;
    logic [4:0]  u_flags;

    // knobs
    int p_req = 0, p_flush = 0, force_lat = -1, flush_age = -1;
    bit flush_at_done = 1'b0, fix_res = 1'b0;
    bit [NT-1:0] t_mask = '1;

    int          last_resp_cyc = -1;
    logic [NT-1:0] last_grant = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < MAXC; i++) begin
            e_grant[i] = -1; e_resp[i] = -1; e_kill[i] = 1'b0; e_busy[i] = 1'b0;
            e_data[i] = 32'd0; e_flags[i] = 5'd0;
        end
        for (int t = 0; t < NT; t++) pend[t] = 1'b0;
        m_active = 1'b0; m_own = 0; m_g = 0; m_rr = 0;
        err_from = 1 << 30; done_cyc = -1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; flush = '0; unit_done = 1'b0; unit_result = 32'd0; unit_fflags = 5'd0;
        req_is_sqrt = '0; req_lhs = '0; req_rhs = '0; req_rm = '0;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_unit_start", unit_start, 0);
        chk("rst_unit_kill", unit_kill, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_unit_ops", {unit_lhs, unit_rhs}, 64'd0);
        chk("rst_unit_ctl", {unit_rm, unit_is_sqrt}, 0);
        chk("rst_resp_data", {resp_data, resp_fflags}, 0);
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        m_free = cyc + 1;
    endtask

    task automatic drive_inputs(input int c);
        int lat;
        if (e_grant[c] >= 0) begin
            pend[e_grant[c]] = 1'b0;
            if (force_lat >= 0) lat = force_lat;
            else if ($urandom_range(0, 19) == 0) lat = 1000;
            else lat = int'($urandom_range(1, 12));
            done_cyc = c + lat;
            u_res    = fix_res ? 32'h4040_0000 : $urandom;
            u_flags  = 5'($urandom);
        end
        for (int t = 0; t < NT; t++) begin
            if (!pend[t] && t_mask[t] && e_grant[c] != t && $urandom_range(0, 99) < p_req) begin
                pend[t] = 1'b1; t_lhs[t] = $urandom; t_rhs[t] = $urandom;
                t_rm[t] = 3'($urandom); t_sqrt[t] = 1'($urandom);
            end
        end
        flush = '0;
        for (int t = 0; t < NT; t++) if ($urandom_range(0, 99) < p_flush) flush[t] = 1'b1;
        if (m_active && flush_age >= 0 && (c - m_g) == flush_age) flush[m_own] = 1'b1;
        if (m_active && flush_at_done && c == done_cyc) flush[m_own] = 1'b1;
        for (int t = 0; t < NT; t++) begin
            req[t] = pend[t]; req_is_sqrt[t] = t_sqrt[t];
            req_lhs[32*t +: 32] = t_lhs[t]; req_rhs[32*t +: 32] = t_rhs[t]; req_rm[3*t +: 3] = t_rm[t];
        end
        unit_done = (c == done_cyc); unit_result = u_res; unit_fflags = u_flags;
    endtask

    task automatic compare(input int c);
        logic [NT-1:0] x_grant, x_resp;
        x_grant = '0; x_resp = '0;
        if (e_grant[c] >= 0) x_grant[e_grant[c]] = 1'b1;
        if (e_resp[c] >= 0 && !flush[e_resp[c]]) x_resp[e_resp[c]] = 1'b1;
        chk("grant", grant, x_grant);
        chk("unit_start", unit_start, e_grant[c] >= 0);
        chk("unit_kill", unit_kill, e_kill[c]);
        chk("busy", busy, e_busy[c]);
        chk("resp_valid", resp_valid, x_resp);
        chk("err_timeout", err_timeout, c >= err_from);
        if (x_resp != '0) begin
            chk("resp_data", resp_data, e_data[c]);
            chk("resp_fflags", resp_fflags, e_flags[c]);
        end
        if (m_active) begin
            chk("unit_lhs", unit_lhs, m_lhs);
            chk("unit_rhs", unit_rhs, m_rhs);
            chk("unit_rm_sqrt", {unit_rm, unit_is_sqrt}, {m_rm, m_sqrt});
        end
        if (resp_valid != '0) last_resp_cyc = c;
        if (grant != '0) last_grant = grant;
    endtask

    task automatic model_step(input int c);
        if (m_active) begin
            if (c == done_cyc && !flush[m_own]) begin
                e_resp[c+1] = m_own; e_data[c+1] = u_res; e_flags[c+1] = u_flags;
                e_busy[c+1] = 1'b1; m_free = c + 2; m_active = 1'b0;
            end else if (flush[m_own]) begin
                e_kill[c+1] = (c != done_cyc);
                m_free = c + 1; m_active = 1'b0; done_cyc = -1;
            end else if (c - m_g == TO - 1) begin
                e_kill[c+1] = 1'b1;
                if (err_from > c + 1) err_from = c + 1;
                m_free = c + 1; m_active = 1'b0; done_cyc = -1;
            end else begin
                e_busy[c+1] = 1'b1;
            end
        end else if (c >= m_free) begin
            for (int k = 0; k < NT; k++) begin
                int t;
                t = (m_rr + k) % NT;
                if (!m_active && pend[t] && !flush[t]) begin
                    m_active = 1'b1; m_own = t; m_g = c + 1; m_rr = (t + 1) % NT;
                    m_lhs = t_lhs[t]; m_rhs = t_sqrt[t] ? 32'd0 : t_rhs[t];
                    m_rm = t_rm[t]; m_sqrt = t_sqrt[t];
                    e_grant[c+1] = t; e_busy[c+1] = 1'b1;
                end
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            cyc++;
            drive_inputs(cyc);
            @(negedge clk);
            compare(cyc);
            model_step(cyc);
            for (int t = 0; t < NT; t++) if (flush[t]) pend[t] = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        for (int t = 0; t < NT; t++) begin
            t_lhs[t] = 32'd0; t_rhs[t] = 32'd0; t_rm[t] = 3'd0; t_sqrt[t] = 1'b0;
        end
        u_res = 32'd0; u_flags = 5'd0;
        #1;
        do_reset();

        // single fdiv from T0, unit latency 10
        pend[0] = 1'b1; t_lhs[0] = 32'h4040_0000; t_rhs[0] = 32'h3F80_0000;
        t_rm[0] = 3'd0; t_sqrt[0] = 1'b0;
        force_lat = 10; fix_res = 1'b1;
        run(16);
        chk("t0_resp_cycle", last_resp_cyc, 12);
        fix_res = 1'b0;

        // both threads holding requests: alternation
        p_req = 100; force_lat = 3;
        run(60);
        p_req = 0;
        run(20);

        // owner flush at BUSY cycle 4 with another thread pending
        pend[1] = 1'b1; force_lat = 20; flush_age = 4;
        run(2);
        pend[0] = 1'b1;
        run(8);
        flush_age = -1;
        run(30);

        // flush coinciding with done
        pend[0] = 1'b1; force_lat = 5; flush_at_done = 1'b1;
        run(12);
        flush_at_done = 1'b0;

        // unit never finishes: timeout, then normal service
        pend[0] = 1'b1; force_lat = 1000;
        run(70);
        force_lat = 4; pend[1] = 1'b1;
        run(15);
        chk("err_sticky", err_timeout, 1);

        // reset in the middle of an operation, then a T1-only request
        pend[0] = 1'b1; force_lat = 30;
        run(5);
        chk("busy_before_rst", busy, 1);
        do_reset();
        last_grant = '0; force_lat = 4; pend[1] = 1'b1;
        run(10);
        chk("rst_rr_t1", last_grant, 2'b10);

        // randomized traffic with flushes and occasional hung ops
        p_req = 35; p_flush = 4; force_lat = -1;
        run(3000);
        p_req = 0; p_flush = 0;
        run(80);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
